pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a five-stage pipeline (IF, ID, EX, Mem, Wr).
//   It resolves RAW hazards by forwarding or stalling, and stalls the front
//   end while a multi-cycle EX operation runs. It redirects the PC on taken
//   branches and jumps, and counts stall and flush cycles.
//
//   Parameters
//     REG_AW  register-address width
//     MC_LAT  multi-cycle EX-op latency in cycles (3..15)
//     FWD_EN  1 = forward from Ex/Mem and Mem/Wr, 0 = stall on every RAW hazard
//     CNT_W   performance-counter width
//
//   Ports
//     clk, rst                        clock (rising edge), async active-high reset
//     rs_id, rt_id, use_rs_id/rt_id   sources of the instruction in ID
//     rs_ex, rt_ex                    sources of the instruction in EX
//     rd_ex/mem/wr, regwr_ex/mem/wr   write targets and write enables per stage
//     memtoreg_ex                     EX instruction is a load
//     mc_start_ex                     multi-cycle op present in EX
//     jump_id, branch_taken_mem       control-flow events
//     pc_stall, if_id_stall           hold PC / IF-ID register
//     if_id_flush, id_ex_flush,
//     ex_mem_flush                    load a bubble into the register
//     pc_src                          00 PC+4, 01 branch target, 10 jump target
//     fwd_a, fwd_b                    00 register, 01 Ex/Mem, 10 Mem/Wr
//     busy                            multi-cycle op in progress
//     stall_cnt, flush_cnt            saturating event counters
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              use_rs_id,
    input  logic              use_rt_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic [REG_AW-1:0] rd_wr,
    input  logic              regwr_ex,
    input  logic              regwr_mem,
    input  logic              regwr_wr,
    input  logic              memtoreg_ex,
    input  logic              mc_start_ex,
    input  logic              jump_id,
    input  logic              branch_taken_mem,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        pc_src,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {RUN, MC} state_t;

    // The first stall cycle happens in RUN, so MC itself lasts MC_LAT-2 cycles.
    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       raw_hazard;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] dmem,
                                           input logic              wmem,
                                           input logic [REG_AW-1:0] dwr,
                                           input logic              wwr);
        if (wmem && (dmem != '0) && (dmem == src))
            return 2'b01;
        if (wwr && (dwr != '0) && (dwr == src))
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic id_reads(input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs,
                                      input logic              ures,
                                      input logic [REG_AW-1:0] rt,
                                      input logic              uret);
        return (rd != '0) && ((ures && (rs == rd)) || (uret && (rt == rd)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        if (FWD_EN != 0) begin
            fwd_a = fwd_sel(rs_ex, rd_mem, regwr_mem, rd_wr, regwr_wr);
            fwd_b = fwd_sel(rt_ex, rd_mem, regwr_mem, rd_wr, regwr_wr);
        end else begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    // With forwarding only a load in EX is too late; without it any older
    // writer of an ID source forces a stall until it has retired.
    always_comb begin
        if (FWD_EN != 0) begin
            raw_hazard = memtoreg_ex && regwr_ex &&
                         id_reads(rd_ex, rs_id, use_rs_id, rt_id, use_rt_id);
        end else begin
            raw_hazard = (regwr_ex  && id_reads(rd_ex,  rs_id, use_rs_id, rt_id, use_rt_id)) ||
                         (regwr_mem && id_reads(rd_mem, rs_id, use_rs_id, rt_id, use_rt_id)) ||
                         (regwr_wr  && id_reads(rd_wr,  rs_id, use_rs_id, rt_id, use_rt_id));
        end
    end

    // Priority: taken branch > multi-cycle op > data hazard > jump.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = 2'b00;
        state_next   = state;
        cnt_next     = cnt;
        if (branch_taken_mem) begin
            pc_src       = 2'b01;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = RUN;
            cnt_next     = 4'd0;
        end else if (state == MC) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_next     = cnt - 4'd1;
            if (cnt == 4'd1)
                state_next = RUN;
        end else if (mc_start_ex) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = MC;
            cnt_next     = MC_LOAD;
        end else if (raw_hazard) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (jump_id) begin
            pc_src       = 2'b10;
            if_id_flush  = 1'b1;
        end
    end

    assign busy = (state == MC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            stall_cnt <= sat_inc(stall_cnt, pc_stall);
            flush_cnt <= sat_inc(flush_cnt, if_id_flush);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: a default instance (FWD_EN=1, CNT_W=16) and
// a stall-only instance (FWD_EN=0, CNT_W=4) share one input stream.
module tb_pipe_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wr;
    logic use_rs_id, use_rt_id, regwr_ex, regwr_mem, regwr_wr;
    logic memtoreg_ex, mc_start_ex, jump_id, branch_taken_mem;

    logic        pcs_a, ifs_a, iff_a, idf_a, exf_a, busy_a;
    logic [1:0]  src_a, fa_a, fb_a;
    logic [15:0] sc_a, fc_a;
    logic        pcs_b, ifs_b, iff_b, idf_b, exf_b, busy_b;
    logic [1:0]  src_b, fa_b, fb_b;
    logic [3:0]  sc_b, fc_b;

    pipe_hazard_ctrl #(.REG_AW(AW), .MC_LAT(LAT), .FWD_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wr(rd_wr), .regwr_ex(regwr_ex),
        .regwr_mem(regwr_mem), .regwr_wr(regwr_wr), .memtoreg_ex(memtoreg_ex),
        .mc_start_ex(mc_start_ex), .jump_id(jump_id), .branch_taken_mem(branch_taken_mem),
        .pc_stall(pcs_a), .if_id_stall(ifs_a), .if_id_flush(iff_a), .id_ex_flush(idf_a),
        .ex_mem_flush(exf_a), .pc_src(src_a), .fwd_a(fa_a), .fwd_b(fb_a), .busy(busy_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a));

    pipe_hazard_ctrl #(.REG_AW(AW), .MC_LAT(LAT), .FWD_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wr(rd_wr), .regwr_ex(regwr_ex),
        .regwr_mem(regwr_mem), .regwr_wr(regwr_wr), .memtoreg_ex(memtoreg_ex),
        .mc_start_ex(mc_start_ex), .jump_id(jump_id), .branch_taken_mem(branch_taken_mem),
        .pc_stall(pcs_b), .if_id_stall(ifs_b), .if_id_flush(iff_b), .id_ex_flush(idf_b),
        .ex_mem_flush(exf_b), .pc_src(src_b), .fwd_a(fa_b), .fwd_b(fb_b), .busy(busy_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b));

    // Output word layout: {pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    //                      ex_mem_flush, pc_src[1:0], fwd_a[1:0], fwd_b[1:0], busy}
    typedef struct {
        logic [AW-1:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wr;
        logic [8:0]    ctl;  // use_rs, use_rt, regwr_ex, regwr_mem, regwr_wr, memtoreg, mc_start, jump, branch
        logic [11:0]   exp;  // expected word for the FWD_EN=1 instance
    } vec_t;

    vec_t tab[14];

    int vectors = 0;
    int errors  = 0;
    int mc_rem  = 0;   // multi-cycle stall cycles still owed after the current one
    int sc1 = 0, fc1 = 0, sc2 = 0, fc2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic id_match(input logic [AW-1:0] r);
        return (r != 0) && ((use_rs_id && rs_id == r) || (use_rt_id && rt_id == r));
    endfunction

    function automatic logic [1:0] fsel(input bit fe, input logic [AW-1:0] s);
        if (!fe) return 2'b00;
        if (regwr_mem && rd_mem != 0 && rd_mem == s) return 2'b01;
        if (regwr_wr && rd_wr != 0 && rd_wr == s) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model_out(input bit fe);
        logic haz;
        logic [4:0] ctl;
        logic [1:0] ps;
        if (fe) haz = memtoreg_ex && regwr_ex && id_match(rd_ex);
        else    haz = (regwr_ex && id_match(rd_ex)) || (regwr_mem && id_match(rd_mem)) ||
                      (regwr_wr && id_match(rd_wr));
        ps = 2'b00;
        if (branch_taken_mem)                  begin ctl = 5'b00111; ps = 2'b01; end
        else if (mc_rem > 0 || mc_start_ex)    ctl = 5'b11001;
        else if (haz)                          ctl = 5'b11010;
        else if (jump_id)                      begin ctl = 5'b00100; ps = 2'b10; end
        else                                   ctl = 5'b00000;
        return {ctl, ps, fsel(fe, rs_ex), fsel(fe, rt_ex), logic'(mc_rem > 0)};
    endfunction

    function automatic int sat(input int v, input bit inc, input int mx);
        return (inc && v < mx) ? v + 1 : v;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input string name, input bit has_tab, input logic [11:0] tab_exp);
        logic [11:0] e1, e2, g1, g2;
        @(negedge clk);
        e1 = model_out(1'b1);
        e2 = model_out(1'b0);
        g1 = {pcs_a, ifs_a, iff_a, idf_a, exf_a, src_a, fa_a, fb_a, busy_a};
        g2 = {pcs_b, ifs_b, iff_b, idf_b, exf_b, src_b, fa_b, fb_b, busy_b};
        if (has_tab) chk($sformatf("%s_table", name), 32'(g1), 32'(tab_exp));
        chk($sformatf("%s_outs_fwd", name), 32'(g1), 32'(e1));
        chk($sformatf("%s_outs_nofwd", name), 32'(g2), 32'(e2));
        chk($sformatf("%s_cnt_fwd", name), {sc_a, fc_a}, {sc1[15:0], fc1[15:0]});
        chk($sformatf("%s_cnt_nofwd", name), 32'({sc_b, fc_b}), 32'({sc2[3:0], fc2[3:0]}));
        @(posedge clk);
        sc1 = sat(sc1, e1[11], 65535);
        fc1 = sat(fc1, e1[9], 65535);
        sc2 = sat(sc2, e2[11], 15);
        fc2 = sat(fc2, e2[9], 15);
        if (branch_taken_mem) mc_rem = 0;
        else if (mc_rem > 0)  mc_rem = mc_rem - 1;
        else if (mc_start_ex) mc_rem = LAT - 2;
        #1;
    endtask

    task automatic clear_inputs();
        {rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wr} = '0;
        {use_rs_id, use_rt_id, regwr_ex, regwr_mem, regwr_wr} = '0;
        {memtoreg_ex, mc_start_ex, jump_id, branch_taken_mem} = '0;
    endtask

    // Called just after a rising edge; checks the asynchronous clear before the next edge.
    task automatic do_reset(input string name);
        rst = 1'b1;
        #2;
        chk($sformatf("%s_rst_busy", name), {31'd0, busy_a | busy_b}, 32'd0);
        chk($sformatf("%s_rst_cnt_fwd", name), {sc_a, fc_a}, 32'd0);
        chk($sformatf("%s_rst_cnt_nofwd", name), 32'({sc_b, fc_b}), 32'd0);
        mc_rem = 0; sc1 = 0; fc1 = 0; sc2 = 0; fc2 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        //            rs_id rt_id rs_ex rt_ex rd_ex rd_mem rd_wr  ctl           exp
        tab[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000000000, 12'h000};
        tab[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 9'b000110000, 12'h008};
        tab[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 9'b000010000, 12'h010};
        tab[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000110000, 12'h000};
        tab[4]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 9'b000010000, 12'h004};
        tab[5]  = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 9'b101001000, 12'hD00};
        tab[6]  = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 9'b001001000, 12'h000};
        tab[7]  = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 9'b011001000, 12'hD00};
        tab[8]  = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 9'b100001000, 12'h000};
        tab[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000000010, 12'h240};
        tab[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000000001, 12'h3A0};
        tab[11] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 9'b101001011, 12'h3A0};
        tab[12] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 9'b101001010, 12'hD00};
        tab[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b101001000, 12'h000};

        @(posedge clk);
        #1;
        do_reset("init");

        for (int i = 0; i < 14; i++) begin
            rs_id = tab[i].rs_id; rt_id = tab[i].rt_id; rs_ex = tab[i].rs_ex; rt_ex = tab[i].rt_ex;
            rd_ex = tab[i].rd_ex; rd_mem = tab[i].rd_mem; rd_wr = tab[i].rd_wr;
            {use_rs_id, use_rt_id, regwr_ex, regwr_mem, regwr_wr, memtoreg_ex,
             mc_start_ex, jump_id, branch_taken_mem} = tab[i].ctl;
            step($sformatf("row%0d", i), 1'b1, tab[i].exp);
        end

        // Load-use: one bubble, then the load has moved on.
        clear_inputs();
        do_reset("lu");
        rd_ex = 5'd2; memtoreg_ex = 1'b1; regwr_ex = 1'b1; rs_id = 5'd2; use_rs_id = 1'b1;
        step("lu_hit", 1'b1, 12'hD00);
        clear_inputs();
        step("lu_after", 1'b1, 12'h000);
        chk("lu_stall_cnt", 32'(sc_a), 32'd1);

        // Multi-cycle op: three stall cycles, two busy cycles.
        do_reset("mc");
        mc_start_ex = 1'b1;
        step("mc_start", 1'b1, 12'hC80);
        mc_start_ex = 1'b0;
        step("mc_busy1", 1'b1, 12'hC81);
        step("mc_busy2", 1'b1, 12'hC81);
        step("mc_done", 1'b1, 12'h000);
        chk("mc_stall_cnt", 32'(sc_a), 32'd3);

        // Taken branch in the second MC cycle aborts the op.
        do_reset("br");
        mc_start_ex = 1'b1;
        step("br_start", 1'b0, 12'h0);
        mc_start_ex = 1'b0;
        step("br_mc1", 1'b0, 12'h0);
        branch_taken_mem = 1'b1;
        step("br_mc2", 1'b1, 12'h3A1);
        branch_taken_mem = 1'b0;
        step("br_after", 1'b1, 12'h000);

        // Jump held behind a load-use stall.
        do_reset("jp");
        rd_ex = 5'd2; memtoreg_ex = 1'b1; regwr_ex = 1'b1; rs_id = 5'd2; use_rs_id = 1'b1;
        jump_id = 1'b1;
        step("jp_stall", 1'b1, 12'hD00);
        {rd_ex, memtoreg_ex, regwr_ex} = '0;
        step("jp_taken", 1'b1, 12'h240);
        clear_inputs();
        step("jp_idle", 1'b1, 12'h000);
        chk("jp_flush_cnt", 32'(fc_a), 32'd1);

        // Stall-only instance: persistent RAW match saturates its 4-bit counter.
        do_reset("sat");
        rs_id = 5'd3; use_rs_id = 1'b1; rd_wr = 5'd3; regwr_wr = 1'b1;
        for (int i = 0; i < 20; i++) step("sat", 1'b0, 12'h0);
        chk("sat_stall_cnt", 32'(sc_b), 32'd15);
        clear_inputs();
        mc_start_ex = 1'b1;
        step("rmc_start", 1'b0, 12'h0);
        mc_start_ex = 1'b0;
        step("rmc_mc1", 1'b0, 12'h0);
        do_reset("rmc");
        step("rmc_after", 1'b0, 12'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                clear_inputs();
                do_reset("rnd");
            end
            rs_id = AW'($urandom_range(0, 3)); rt_id = AW'($urandom_range(0, 3));
            rs_ex = AW'($urandom_range(0, 3)); rt_ex = AW'($urandom_range(0, 3));
            rd_ex = AW'($urandom_range(0, 3)); rd_mem = AW'($urandom_range(0, 3));
            rd_wr = AW'($urandom_range(0, 3));
            use_rs_id = 1'($urandom_range(0, 1)); use_rt_id = 1'($urandom_range(0, 1));
            regwr_ex = 1'($urandom_range(0, 1)); regwr_mem = 1'($urandom_range(0, 1));
            regwr_wr = 1'($urandom_range(0, 1)); memtoreg_ex = 1'($urandom_range(0, 1));
            mc_start_ex = ($urandom_range(0, 11) == 0);
            jump_id = ($urandom_range(0, 5) == 0);
            branch_taken_mem = ($urandom_range(0, 15) == 0);
            step("rnd", 1'b0, 12'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
